// File: rtl/multisim_pull_upsizer.sv
// multisim_pull_upsizer: packs RATIO narrow beats from a multisim pull client
// into one wide word and presents it on a registered vld/rdy output.
// The first beat of a word ends up in the lowest IN_WIDTH bits.
// Optional build macro MULTISIM_UPSIZER_STATS_EN adds the words_out and
// stall_cycles counters. MULTISIM_SIMULATION_4_STATE selects a logic payload
// element type (bit otherwise).
module multisim_pull_upsizer #(
    parameter int IN_WIDTH = 64,
    parameter int RATIO    = 4,
`ifdef MULTISIM_SIMULATION_4_STATE
    parameter type multisim_data_t = logic
`else
    parameter type multisim_data_t = bit
`endif
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  in_vld,
    output logic                                  in_rdy,
    input  multisim_data_t [IN_WIDTH-1:0]         in_data,
    output logic                                  out_vld,
    input  logic                                  out_rdy,
    output multisim_data_t [IN_WIDTH*RATIO-1:0]   out_data
`ifdef MULTISIM_UPSIZER_STATS_EN
    ,
    output logic [31:0]                           words_out,
    output logic [31:0]                           stall_cycles
`endif
);

    localparam int OUT_WIDTH = IN_WIDTH * RATIO;
    localparam int CNT_W     = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RATIO - 1);

    logic [CNT_W-1:0]               cnt;
    logic                           last_beat;
    logic                           in_fire;
    logic                           out_fire;
    multisim_data_t [OUT_WIDTH-1:0] word_next;

    // The final beat is held off only while the output register is full and
    // not draining; every other beat lands in the accumulator.
    assign last_beat = (cnt == CNT_LAST);
    assign in_rdy    = !(last_beat && out_vld && !out_rdy);
    assign in_fire   = in_vld && in_rdy;
    assign out_fire  = out_vld && out_rdy;

    generate
        if (RATIO > 1) begin : g_acc
            multisim_data_t [(RATIO-1)*IN_WIDTH-1:0] acc;

            // Capture non-final beats into the lane selected by cnt
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    acc <= '0;
                end else if (in_fire && !last_beat) begin
                    for (int k = 0; k < RATIO - 1; k++) begin
                        if (cnt == CNT_W'(k))
                            acc[k*IN_WIDTH +: IN_WIDTH] <= in_data;
                    end
                end
            end

            // Final beat goes straight to the top lane, no extra cycle
            assign word_next = {in_data, acc};
        end else begin : g_pass
            assign word_next = in_data;
        end
    endgenerate

    // Beat counter: 0..RATIO-1, wraps when the word completes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (in_fire)
            cnt <= last_beat ? '0 : cnt + CNT_W'(1);
    end

    // Output register: a load wins over a drain on the same edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_vld  <= 1'b0;
            out_data <= '0;
        end else begin
            if (in_fire && last_beat) begin
                out_vld  <= 1'b1;
                out_data <= word_next;
            end else if (out_rdy) begin
                out_vld  <= 1'b0;
            end
        end
    end

`ifdef MULTISIM_UPSIZER_STATS_EN
    // Saturating event counters for delivered words and back-pressure cycles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            words_out    <= '0;
            stall_cycles <= '0;
        end else begin
            if (out_fire && words_out != 32'hFFFF_FFFF)
                words_out <= words_out + 32'd1;
            if (out_vld && !out_rdy && stall_cycles != 32'hFFFF_FFFF)
                stall_cycles <= stall_cycles + 32'd1;
        end
    end
`endif

endmodule
